dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage ("core") and a program/data loader or debug port ("dma").
- Sits between both requesters and the data memory macro. The memory has a combinational 32-bit little-endian read and a word write on posedge clk when memwrite is high.
- Arbitrates with core priority, DMA starvation protection and bounded DMA bursts.
- Rejects misaligned and out-of-range accesses, and returns registered read data and acknowledges.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; fixed at 32 (word access only).
- MEM_BYTES, 110, byte size of the attached memory; the highest legal word address is MEM_BYTES-4.
- MAX_WAIT, 4, number of consecutive denied DMA request cycles before DMA wins over core.
- BURST_LEN, 4, maximum number of consecutive DMA grants before core regains priority; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  write data.
- core_gnt  out  1  combinational grant; access is performed this cycle.
- core_stall  out  1  core_req & ~core_gnt; drives the pipeline freeze.
- core_rvalid  out  1  registered response pulse, one cycle after grant.
- core_rdata  out  DATA_W  registered read data.
- core_err  out  1  registered error flag; valid with core_rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same directions, widths and meanings as the core_* ports, for the DMA side.
- mem_addr  out  ADDR_W  address to the memory.
- mem_wdata  out  DATA_W  write data to the memory.
- mem_memwrite  out  1  write strobe to the memory.
- mem_rdata  in  DATA_W  combinational read data from the memory.

Behaviour:
- Reset: state=S_IDLE; starve_cnt=0; beat_cnt=0; all rvalid, rdata and err outputs = 0. With reset high, no grant is issued and mem_memwrite=0.
- Reset mid-burst: the burst aborts, and any response due next cycle is dropped (rvalid stays 0).
- Grant rules:
  - At most one grant per cycle.
  - Grants are decoded combinationally from registered state plus the current requests.
  - A requester must hold its req, addr and wdata stable until gnt is seen.
- S_IDLE:
  - DMA is granted if dma_req & (~core_req | starve_cnt==MAX_WAIT). Then beat_cnt<=1, and next state = S_DMA_BURST if BURST_LEN>1, else S_IDLE.
  - Otherwise, core is granted if core_req.
- S_DMA_BURST:
  - If dma_req: DMA is granted and beat_cnt<=beat_cnt+1. If beat_cnt+1==BURST_LEN, go to S_IDLE; otherwise stay.
  - If ~dma_req: core is granted if core_req, and the state goes to S_IDLE.
- starve_cnt:
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears to 0 on dma_gnt or ~dma_req.
  - Cleared on every S_DMA_BURST→S_IDLE exit.
- Memory drive:
  - mem_addr and mem_wdata follow the granted requester.
  - mem_memwrite = gnt & we & ~err_now.
  - With no grant: mem_addr=0, mem_wdata=0, mem_memwrite=0.
- Error check (err_now): addr[1:0]!=0 OR addr > MEM_BYTES-4; the comparison is unsigned at full ADDR_W.
  - An erroring access still consumes its grant.
  - A write is suppressed.
  - The response carries rdata=0 and err=1.
- Response:
  - Next cycle after any grant: rvalid=1 for the granted side.
  - rdata = mem_rdata sampled at the grant cycle for legal reads; 0 for writes and for errors.
  - err = err_now.
  - rvalid, rdata and err return to 0 the cycle after unless re-granted.
  - Back-to-back grants give back-to-back rvalid.
- Read-after-write: a write granted in cycle N is visible to a read granted in cycle N+1. There is no bypass; the memory commits the write at the posedge.
- Simultaneous requests with starve_cnt<MAX_WAIT: core wins and DMA waits.
- BURST_LEN=1: DMA never holds more than one consecutive cycle.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {S_IDLE, S_DMA_BURST}.
  - Requester id encoding (CORE=0, DMA=1).
  - Default parameter constants.
- Sub-module dmem_addr_check: purely combinational alignment and range check. Takes addr and MEM_BYTES and outputs err. It is instantiated once, on the muxed granted address.
- All other logic (FSM, counters, response registers) lives in dmem_arbiter.

Test Plan:
- Core only: write 0xDEADBEEF @0x10, then read @0x10 → core_gnt=1 both cycles, core_stall=0, and the second core_rvalid shows rdata=0xDEADBEEF, err=0.
- Both req continuously, MAX_WAIT=4: core is granted cycles 0-3, DMA is granted at cycle 4, core_stall=1 at cycle 4, and starve_cnt resets to 0.
- DMA-only burst of 6 writes with core requesting from beat 2, BURST_LEN=4: DMA is granted for 4 beats, core is granted at beat 5, and the remaining DMA beats follow the starvation rules.
- Error cases: misaligned read @0x13 → rvalid=1, err=1, rdata=0. Write @0x6C (>106) → err=1 and mem_memwrite stays 0, so memory is unchanged.
- Reset asserted during DMA beat 2 → next cycle dma_rvalid=0, state S_IDLE, counters 0. The first grant after reset goes to core if both request.
- Core write @0x20=0x1234 in cycle N and DMA read @0x20 granted in N+1 → dma_rdata=0x00001234.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   state_t : arbiter FSM states
//   CORE/DMA: requester ids, used to index per-requester vectors
//   rsp_t   : registered response bundle returned to a requester
package dmem_arb_pkg;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_DMA_BURST = 1'b1
  } state_t;

  localparam int CORE    = 0;
  localparam int DMA     = 1;
  localparam int NUM_REQ = 2;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_BYTES_DEF = 110;
  localparam int MAX_WAIT_DEF  = 4;
  localparam int BURST_LEN_DEF = 4;

  typedef struct packed {
    logic                  rvalid;
    logic                  err;
    logic [DATA_W_DEF-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational legality check for a word access.
//   addr : byte address of the access
//   err  : 1 when addr is not word aligned or the word would run past
//          the last legal word address (MEM_BYTES-4), unsigned compare
module dmem_addr_check #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 110
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  assign err = (addr[1:0] != 2'b00) || (addr > LAST_WORD);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory.
//   core_* : pipeline MEM stage port (priority requester)
//   dma_*  : loader / debug port, protected from starvation and allowed
//            bounded bursts
//   *_gnt  : combinational grant, access happens in the same cycle
//   *_rvalid/_rdata/_err : registered response, one cycle after grant
//   mem_*  : drive to the memory macro (combinational read, write on
//            posedge when mem_memwrite is high)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (MAX_WAIT  < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int BW = (BURST_LEN < 1) ? 1 : $clog2(BURST_LEN + 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt, beat_inc;
  logic            starved;

  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_we;
  logic              err_now;

  rsp_t rsp_q [NUM_REQ];

  assign req_we[CORE]    = core_we;
  assign req_we[DMA]     = dma_we;
  assign req_addr[CORE]  = core_addr;
  assign req_addr[DMA]   = dma_addr;
  assign req_wdata[CORE] = core_wdata;
  assign req_wdata[DMA]  = dma_wdata;

  assign starved  = (starve_cnt == SW'(MAX_WAIT));
  assign beat_inc = beat_cnt + 1'b1;

  // Grant decode and next state. Reset blocks every grant so nothing is
  // written and no response is queued while reset is held.
  always_comb begin
    gnt       = '0;
    state_nxt = state;
    beat_nxt  = beat_cnt;
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          if (dma_req && (!core_req || starved)) begin
            gnt[DMA]  = 1'b1;
            beat_nxt  = BW'(1);
            state_nxt = (BURST_LEN > 1) ? S_DMA_BURST : S_IDLE;
          end else if (core_req) begin
            gnt[CORE] = 1'b1;
          end
        end
        S_DMA_BURST: begin
          if (dma_req) begin
            gnt[DMA] = 1'b1;
            beat_nxt = beat_inc;
            if (beat_inc == BW'(BURST_LEN)) state_nxt = S_IDLE;
          end else begin
            gnt[CORE] = core_req;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_comb begin
    starve_nxt = starve_cnt;
    if ((state == S_DMA_BURST && state_nxt == S_IDLE) || gnt[DMA] || !dma_req)
      starve_nxt = '0;
    else if (!starved)
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // Granted-side mux; at most one bit of gnt is set, zeros when idle.
  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_addr  = req_addr[i];
        g_wdata = req_wdata[i];
        g_we    = req_we[i];
      end
    end
  end

  dmem_addr_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .addr (g_addr),
    .err  (err_now)
  );

  assign mem_addr     = g_addr;
  assign mem_wdata    = g_wdata;
  assign mem_memwrite = (|gnt) & g_we & ~err_now;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        rsp_q[i] <= '0;
      end else begin
        rsp_q[i].rvalid <= gnt[i];
        rsp_q[i].err    <= gnt[i] & err_now;
        rsp_q[i].rdata  <= (gnt[i] & ~g_we & ~err_now) ? mem_rdata : '0;
      end
    end
  end

  assign core_gnt    = gnt[CORE];
  assign dma_gnt     = gnt[DMA];
  assign core_stall  = core_req & ~gnt[CORE];
  assign core_rvalid = rsp_q[CORE].rvalid;
  assign core_err    = rsp_q[CORE].err;
  assign core_rdata  = rsp_q[CORE].rdata;
  assign dma_rvalid  = rsp_q[DMA].rvalid;
  assign dma_err     = rsp_q[DMA].err;
  assign dma_rdata   = rsp_q[DMA].rdata;

endmodule
